// File: rtl/moisture_sensor_filter.sv
// moisture_sensor_filter
// Samples the raw 4-bit soil-moisture reading once every SAMPLE_DIV cycles.
// It averages the last 2^AVG_LOG2 samples and drives the result to the
// irrigation controller. Until a full window has been collected, the output
// holds the safe "wet" value 4'hF so the pump stays off.
// Define MOIST_FAULT_EN to build in stuck-at-rail detection. A reading held
// at 4'h0 or 4'hF for STUCK_LIMIT ticks forces the safe value and raises
// `fault`. Without the macro, `fault` is tied low and rail values are
// averaged like any other value.
`timescale 1ns/1ps

module moisture_sensor_filter #(
  parameter int SAMPLE_DIV  = 10,
  parameter int AVG_LOG2    = 2,
  parameter int STUCK_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw,
  output logic [3:0] sensor,
  output logic       sensor_valid,
  output logic       sample_tick,
  output logic       fault
);

  localparam int         DEPTH    = 1 << AVG_LOG2;
  localparam int         SUM_W    = 4 + AVG_LOG2;
  localparam logic [3:0] SAFE_WET = 4'hF;

  // Reject illegal parameter values at elaboration instead of building
  // a filter that silently misbehaves.
  if (SAMPLE_DIV < 2 || SAMPLE_DIV > 255) begin : g_bad_div
    $error("moisture_sensor_filter: SAMPLE_DIV out of range 2..255");
  end
  if (AVG_LOG2 < 1 || AVG_LOG2 > 3) begin : g_bad_avg
    $error("moisture_sensor_filter: AVG_LOG2 out of range 1..3");
  end
  if (STUCK_LIMIT < 2 || STUCK_LIMIT > 15) begin : g_bad_limit
    $error("moisture_sensor_filter: STUCK_LIMIT out of range 2..15");
  end

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1
`ifdef MOIST_FAULT_EN
    ,
    ST_FAULT = 2'd2
`endif
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       div_q;
  logic [3:0]       win_q [DEPTH];
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;
  logic [3:0]       filtered;
  logic [3:0]       fill_q;
  logic             fill_done;
  logic             enter_fault;
  logic             leave_fault;
  logic             in_fault;

  // ---------------------------------------------------------------------
  // Sample-rate divider. The tick decodes straight from the counter, so it
  // is high during the last cycle of each period.
  // ---------------------------------------------------------------------
  assign sample_tick = (div_q == 8'(SAMPLE_DIV - 1));

  // Divider counts 0..SAMPLE_DIV-1 and wraps on the tick.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (sample_tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Running sum: add the incoming sample and drop the oldest one. The sum
  // is wide enough for DEPTH samples of 4'hF, so it can never overflow.
  // ---------------------------------------------------------------------
  assign sum_d     = sum_q + SUM_W'(raw) - SUM_W'(win_q[DEPTH-1]);
  assign filtered  = sum_d[SUM_W-1:AVG_LOG2];
  assign fill_done = (fill_q == 4'(DEPTH - 1));

`ifdef MOIST_FAULT_EN
  // ---------------------------------------------------------------------
  // Stuck-rail detector: count consecutive identical rail samples.
  // ---------------------------------------------------------------------
  logic [3:0] rail_cnt_q, rail_cnt_d, prev_raw_q;
  logic       raw_is_rail;
  logic       stuck_hit;

  // Next rail-run length for the sample currently on `raw`.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    raw_is_rail = (raw == 4'h0) || (raw == 4'hF);
    rail_cnt_d  = 4'd0;
    if (raw_is_rail) begin
      if (raw != prev_raw_q) begin
        rail_cnt_d = 4'd1;
      end else if (rail_cnt_q == 4'(STUCK_LIMIT)) begin
        rail_cnt_d = rail_cnt_q;
      end else begin
        rail_cnt_d = rail_cnt_q + 4'd1;
      end
    end
    stuck_hit = (rail_cnt_d == 4'(STUCK_LIMIT));
  end

  // Rail counter and previous-sample registers advance once per tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rail_cnt_q <= '0;
      prev_raw_q <= '0;
    end else if (sample_tick) begin
      rail_cnt_q <= rail_cnt_d;
      prev_raw_q <= raw;
    end
  end

  assign in_fault    = (state_q == ST_FAULT);
  assign enter_fault = !in_fault && (state_d == ST_FAULT);
  assign leave_fault = in_fault && (state_d != ST_FAULT);
`else
  assign in_fault    = 1'b0;
  assign enter_fault = 1'b0;
  assign leave_fault = 1'b0;
`endif

  assign fault = in_fault;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. Transitions happen only on a sample tick; a stuck rail
  // overrides the normal FILL/RUN flow.
  always_comb begin
    state_d = state_q;
    if (sample_tick) begin
      case (state_q)
        ST_FILL:  if (fill_done) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
`ifdef MOIST_FAULT_EN
        ST_FAULT: if (!raw_is_rail) state_d = ST_FILL;
`endif
        default:  state_d = ST_FILL;
      endcase
`ifdef MOIST_FAULT_EN
      if (!in_fault && stuck_hit) state_d = ST_FAULT;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Window buffer, sum, fill counter and registered outputs. These change
  // only on a tick edge or on reset.
  // NOTE: the window buffer is reset because the running sum assumes every
  // slot starts at zero; a few flops of reset cost less than a stale average.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      sum_q        <= '0;
      fill_q       <= '0;
      sensor       <= SAFE_WET;
      sensor_valid <= 1'b0;
    end else if (sample_tick) begin
      if (leave_fault) begin
        // Restart from an empty window, seeded with this good sample.
        win_q[0] <= raw;
        for (int i = 1; i < DEPTH; i++) win_q[i] <= '0;
        sum_q  <= SUM_W'(raw);
        fill_q <= 4'd1;
      end else if (!in_fault) begin
        win_q[0] <= raw;
        for (int i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
        sum_q <= sum_d;
        if (enter_fault) begin
          fill_q       <= '0;
          sensor       <= SAFE_WET;
          sensor_valid <= 1'b0;
        end else if (state_d == ST_RUN) begin
          sensor       <= filtered;
          sensor_valid <= 1'b1;
        end else begin
          fill_q <= fill_q + 4'd1;
        end
      end
    end
  end

endmodule
